// File: rtl/mfp_ahb_byte_loader.sv
// Packs a byte stream into little-endian words and writes them as single AHB NONSEQ transfers to incrementing addresses.
// Latency: last byte at edge N -> address phase N+1, data phase N+2; in_ready drops outside COLLECT and while load_addr_valid.
module mfp_ahb_byte_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 load_addr_valid,
    input  logic [31:0]          load_addr,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [31:0]          HADDR,
    output logic [2:0]           HBURST,
    output logic                 HMASTLOCK,
    output logic [3:0]           HPROT,
    output logic [2:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [31:0]          HWDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic                 error
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2
    } state_t;

    localparam logic [31:0] RESET_ADDR = {BASE_ADDR[31:2], 2'b00};
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [31:0]            word_q, word_d;
    logic [31:0]            hwdata_q, hwdata_d;
    logic [CNT_WIDTH-1:0]   words_q, words_d;
    logic                   err_q, err_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= COLLECT;
            addr_q   <= RESET_ADDR;
            cnt_q    <= 3'd0;
            word_q   <= 32'd0;
            hwdata_q <= 32'd0;
            words_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            hwdata_q <= hwdata_d;
            words_q  <= words_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        hwdata_d = hwdata_q;
        words_d  = words_q;
        err_d    = err_q;
        case (state_q)
            COLLECT: begin
                // An address load wins over a byte presented in the same cycle.
                if (load_addr_valid) begin
                    addr_d = {load_addr[31:2], 2'b00};
                    cnt_d  = 3'd0;
                    word_d = 32'd0;
                end else if (in_valid) begin
                    word_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3 || in_last) begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (HREADY) begin
                    state_d  = DATA;
                    hwdata_d = word_q;
                end
            end
            DATA: begin
                // Errors are recorded but never retried; loading just moves on.
                if (HREADY) begin
                    state_d = COLLECT;
                    addr_d  = addr_q + 32'd4;
                    words_d = words_q + 1'b1;
                    cnt_d   = 3'd0;
                    word_d  = 32'd0;
                    if (HRESP) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_ready      = (state_q == COLLECT) && !load_addr_valid;
    assign HADDR         = addr_q;
    assign HBURST        = 3'b000;
    assign HMASTLOCK     = 1'b0;
    assign HPROT         = 4'b0011;
    assign HSIZE         = 3'b010;
    assign HTRANS        = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE        = (state_q == ADDR);
    assign HWDATA        = hwdata_q;
    assign busy          = (state_q != COLLECT) || (cnt_q != 3'd0);
    assign words_written = words_q;
    assign error         = err_q;

endmodule

// File: tb/tb_mfp_ahb_byte_loader.sv
// Directed bench for mfp_ahb_byte_loader with hand-computed expected bus values.
module tb_mfp_ahb_byte_loader;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        load_addr_valid;
    logic [31:0] load_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic [15:0] words_written;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;

    mfp_ahb_byte_loader #(.BASE_ADDR(32'h0000_0000), .CNT_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .load_addr_valid(load_addr_valid), .load_addr(load_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .words_written(words_written), .error(error)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered in the address-phase cycle with HREADY=1; leaves in the cycle after the data phase.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input int cnt);
        chk({tag, "_htrans_addr"}, {30'd0, HTRANS}, 32'h2);
        chk({tag, "_hwrite_addr"}, {31'd0, HWRITE}, 32'h1);
        chk({tag, "_haddr"},       HADDR, a);
        chk({tag, "_in_ready_addr"}, {31'd0, in_ready}, 32'h0);
        tick();
        chk({tag, "_htrans_data"}, {30'd0, HTRANS}, 32'h0);
        chk({tag, "_hwrite_data"}, {31'd0, HWRITE}, 32'h0);
        chk({tag, "_hwdata"},      HWDATA, d);
        chk({tag, "_haddr_data"},  HADDR, a);
        tick();
        chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'h1);
        chk({tag, "_words"},       {16'd0, words_written}, cnt);
        chk({tag, "_busy_after"},  {31'd0, busy}, 32'h0);
    endtask

    initial begin
        HRESET = 1'b1; load_addr_valid = 1'b0; load_addr = 32'h0;
        in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        HRESET = 1'b0;

        // Reset state
        chk("rst_htrans", {30'd0, HTRANS}, 32'h0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_words", {16'd0, words_written}, 32'h0);
        chk("rst_error", {31'd0, error}, 32'h0);
        chk("const_hburst", {29'd0, HBURST}, 32'h0);
        chk("const_hsize", {29'd0, HSIZE}, 32'h2);
        chk("const_hprot", {28'd0, HPROT}, 32'h3);
        chk("const_hmastlock", {31'd0, HMASTLOCK}, 32'h0);

        // 1: four bytes -> one word at 0x0
        put_byte(8'h11, 1'b0);
        chk("t1_busy_partial", {31'd0, busy}, 32'h1);
        put_byte(8'h22, 1'b0);
        put_byte(8'h33, 1'b0);
        chk("t1_htrans_collect", {30'd0, HTRANS}, 32'h0);
        put_byte(8'h44, 1'b0);
        do_write("t1", 32'h0, 32'h4433_2211, 1);

        // 2: address load forces alignment, then two words
        load_addr_valid = 1'b1; load_addr = 32'h0000_0103;
        #1;
        chk("t2_in_ready_load", {31'd0, in_ready}, 32'h0);
        tick();
        load_addr_valid = 1'b0;
        chk("t2_haddr_loaded", HADDR, 32'h0000_0100);
        put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b0); put_byte(8'h04, 1'b0);
        do_write("t2a", 32'h100, 32'h0403_0201, 2);
        put_byte(8'h05, 1'b0); put_byte(8'h06, 1'b0); put_byte(8'h07, 1'b0); put_byte(8'h08, 1'b0);
        do_write("t2b", 32'h104, 32'h0807_0605, 3);

        // 3: in_last flushes a partial word; next byte starts fresh
        put_byte(8'hAA, 1'b0);
        put_byte(8'hBB, 1'b1);
        do_write("t3a", 32'h108, 32'h0000_BBAA, 4);
        put_byte(8'hCC, 1'b1);
        do_write("t3b", 32'h10C, 32'h0000_00CC, 5);

        // 4: wait states in both phases; address load and bytes ignored meanwhile
        put_byte(8'h0A, 1'b0); put_byte(8'h0B, 1'b0); put_byte(8'h0C, 1'b0);
        HREADY = 1'b0;
        put_byte(8'h0D, 1'b0);
        in_valid = 1'b1; in_data = 8'hEE;
        load_addr_valid = 1'b1; load_addr = 32'h0000_FFF0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_htrans_hold", {30'd0, HTRANS}, 32'h2);
            chk("t4_haddr_hold", HADDR, 32'h110);
            chk("t4_in_ready_addr", {31'd0, in_ready}, 32'h0);
            if (i < 2) tick();
        end
        load_addr_valid = 1'b0;
        HREADY = 1'b1;
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hwdata_stable", HWDATA, 32'h0D0C_0B0A);
            chk("t4_htrans_data", {30'd0, HTRANS}, 32'h0);
            chk("t4_in_ready_data", {31'd0, in_ready}, 32'h0);
            chk("t4_words_wait", {16'd0, words_written}, 32'd5);
            if (i < 2) tick();
        end
        in_valid = 1'b0;
        HREADY = 1'b1;
        tick();
        chk("t4_words", {16'd0, words_written}, 32'd6);
        chk("t4_busy", {31'd0, busy}, 32'h0);

        // 5: error response is sticky and does not stall
        put_byte(8'h51, 1'b0); put_byte(8'h52, 1'b0); put_byte(8'h53, 1'b0); put_byte(8'h54, 1'b0);
        chk("t5_haddr", HADDR, 32'h114);
        tick();
        chk("t5_hwdata", HWDATA, 32'h5453_5251);
        HRESP = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("t5_error_set", {31'd0, error}, 32'h1);
        chk("t5_words", {16'd0, words_written}, 32'd7);
        put_byte(8'h61, 1'b0); put_byte(8'h62, 1'b0); put_byte(8'h63, 1'b0); put_byte(8'h64, 1'b0);
        do_write("t5b", 32'h118, 32'h6463_6261, 8);
        chk("t5_error_sticky", {31'd0, error}, 32'h1);

        // 6: address load discards partial bytes; reset aborts a data phase
        put_byte(8'h71, 1'b0); put_byte(8'h72, 1'b0);
        chk("t6_busy_partial", {31'd0, busy}, 32'h1);
        in_valid = 1'b1; in_data = 8'h73;
        load_addr_valid = 1'b1; load_addr = 32'h0000_0200;
        #1;
        chk("t6_in_ready_load", {31'd0, in_ready}, 32'h0);
        tick();
        in_valid = 1'b0; load_addr_valid = 1'b0;
        chk("t6_busy_cleared", {31'd0, busy}, 32'h0);
        chk("t6_haddr_loaded", HADDR, 32'h200);
        put_byte(8'h81, 1'b0); put_byte(8'h82, 1'b0); put_byte(8'h83, 1'b0); put_byte(8'h84, 1'b0);
        do_write("t6a", 32'h200, 32'h8483_8281, 9);
        put_byte(8'h91, 1'b0); put_byte(8'h92, 1'b0); put_byte(8'h93, 1'b0); put_byte(8'h94, 1'b0);
        tick();
        chk("t6_in_data_phase", {30'd0, HTRANS}, 32'h0);
        HRESET = 1'b1;
        tick();
        chk("t6_rst_htrans", {30'd0, HTRANS}, 32'h0);
        chk("t6_rst_haddr", HADDR, 32'h0);
        chk("t6_rst_hwdata", HWDATA, 32'h0);
        chk("t6_rst_words", {16'd0, words_written}, 32'h0);
        chk("t6_rst_error", {31'd0, error}, 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'h0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'h1);
        HRESET = 1'b0;
        tick();
        chk("t6_idle_after", {30'd0, HTRANS}, 32'h0);
        chk("t6_words_after", {16'd0, words_written}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
